// File: rtl/reduce_buffer_drain_seq.sv
// Read side of the reduce buffer: waits for the writer, streams 2^n entries through a
// credit-controlled FWFT FIFO. Optional macro REDUCE_DRAIN_CLEAR_EN adds zero write-back.
module reduce_buffer_drain_seq #(
  parameter int DATA_WIDTH          = 64,
  parameter int ADDR_WIDTH          = 12,
  parameter int COMMON_BRAM_LATENCY = 1,
  localparam int N_POLY      = 2,
  localparam int LEVEL_WIDTH = 4,
  localparam int FIFO_DEPTH  = COMMON_BRAM_LATENCY + 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic [LEVEL_WIDTH-1:0]       i_n,
  input  logic                         i_wr_done,
  output logic [ADDR_WIDTH-1:0]        o_addr_rb,
  output logic                         o_en_rb,
  input  logic [N_POLY*DATA_WIDTH-1:0] i_data_rb,
  output logic [N_POLY*DATA_WIDTH-1:0] o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_last,
  output logic                         o_busy,
  output logic                         o_done
`ifdef REDUCE_DRAIN_CLEAR_EN
  ,
  output logic [ADDR_WIDTH-1:0]        o_addr_clr,
  output logic                         o_we_clr,
  output logic [N_POLY*DATA_WIDTH-1:0] o_data_clr
`endif
);

  localparam int ENTRY_W = N_POLY * DATA_WIDTH;
  localparam int LAT     = COMMON_BRAM_LATENCY;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int CW1     = CNT_W + 1;
  localparam int CTR_W   = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, FLUSH} state_t;

  state_t                 state, state_nxt;
  logic [LEVEL_WIDTH-1:0] n_q, n_eff;
  logic [CTR_W-1:0]       rd_cnt, last_addr;
  logic                   vld_pipe  [LAT];
  logic                   last_pipe [LAT];
  logic [CNT_W-1:0]       inflight, fifo_count, wr_idx;
  logic [ENTRY_W:0]       fifo_mem [FIFO_DEPTH];
  logic [ENTRY_W:0]       fifo_nxt [FIFO_DEPTH];
  logic                   issue, issue_last, push, pop, credit_ok, start_drain;

  always_comb begin
    n_eff = n_q;
    if (int'(n_q) > ADDR_WIDTH) n_eff = LEVEL_WIDTH'(ADDR_WIDTH);
  end

  assign last_addr   = (CTR_W'(1) << n_eff) - CTR_W'(1);
  assign o_valid     = (fifo_count != '0);
  assign pop         = o_valid & i_ready;
  assign push        = vld_pipe[LAT-1];
  // Credits cover both FIFO occupancy and reads whose data is still in the BRAM pipe.
  assign credit_ok   = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW1'(FIFO_DEPTH) + CW1'(pop));
  assign issue       = (state == DRAIN) && credit_ok;
  assign issue_last  = issue && (rd_cnt == last_addr);
  assign start_drain = (state == IDLE) && i_start;

  assign o_en_rb   = issue;
  assign o_addr_rb = rd_cnt[ADDR_WIDTH-1:0];
  assign o_data    = fifo_mem[0][ENTRY_W-1:0];
  assign o_last    = o_valid & fifo_mem[0][ENTRY_W];
  assign o_busy    = (state != IDLE);
  assign o_done    = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (i_start) state_nxt = i_wr_done ? DRAIN : WAIT;
      WAIT:  if (i_wr_done) state_nxt = DRAIN;
      DRAIN: if (issue_last) state_nxt = FLUSH;
      // Leave once nothing remains in flight or buffered after this cycle's push/pop.
      FLUSH: if ((inflight == CNT_W'(push)) &&
                 ((fifo_count + CNT_W'(push)) == CNT_W'(pop))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-register FIFO: the head always sits in slot 0, so the output is a plain register.
  always_comb begin
    wr_idx = fifo_count - CNT_W'(pop);
    for (int i = 0; i < FIFO_DEPTH; i++) fifo_nxt[i] = fifo_mem[i];
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) fifo_nxt[i] = fifo_mem[i+1];
      fifo_nxt[FIFO_DEPTH-1] = '0;
    end
    if (push) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        if (wr_idx == CNT_W'(i)) fifo_nxt[i] = {last_pipe[LAT-1], i_data_rb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q        <= '0;
      rd_cnt     <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      for (int i = 0; i < LAT; i++) begin
        vld_pipe[i]  <= 1'b0;
        last_pipe[i] <= 1'b0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (start_drain) begin
        n_q    <= i_n;
        rd_cnt <= '0;
      end else if (issue) begin
        rd_cnt <= rd_cnt + CTR_W'(1);
      end
      vld_pipe[0]  <= issue;
      last_pipe[0] <= issue_last;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
      inflight   <= inflight + CNT_W'(issue) - CNT_W'(push);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= fifo_nxt[i];
    end
  end

`ifdef REDUCE_DRAIN_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_addr_pipe [LAT];

  // Zero write-back lands the same cycle the read data is captured into the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) clr_addr_pipe[i] <= '0;
    end else begin
      clr_addr_pipe[0] <= rd_cnt[ADDR_WIDTH-1:0];
      for (int i = 1; i < LAT; i++) clr_addr_pipe[i] <= clr_addr_pipe[i-1];
    end
  end

  assign o_we_clr   = vld_pipe[LAT-1];
  assign o_addr_clr = clr_addr_pipe[LAT-1];
  assign o_data_clr = '0;
`endif

endmodule

// File: tb/tb_reduce_buffer_drain_seq.sv
// Scoreboard bench for reduce_buffer_drain_seq with a 1-cycle BRAM model.
module tb_reduce_buffer_drain_seq;
  localparam int DW = 64;
  localparam int AW = 12;
  localparam int EW = 2 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic [3:0]    i_n;
  logic          i_wr_done;
  logic [AW-1:0] o_addr_rb;
  logic          o_en_rb;
  logic [EW-1:0] i_data_rb;
  logic [EW-1:0] o_data;
  logic          o_valid;
  logic          i_ready;
  logic          o_last;
  logic          o_busy;
  logic          o_done;
`ifdef REDUCE_DRAIN_CLEAR_EN
  logic [AW-1:0] o_addr_clr;
  logic          o_we_clr;
  logic [EW-1:0] o_data_clr;
`endif

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  logic [EW:0] sb [$];
  logic [EW:0] mon_e;

  int res_first_valid, res_first_en, res_first_addr, res_done;
  int res_en_blocked, res_busy1, res_done1, res_held_bad, res_clr_count;
  logic [EW-1:0] res_head19;

  always #5 clk = ~clk;

  reduce_buffer_drain_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_n       (i_n),
    .i_wr_done (i_wr_done),
    .o_addr_rb (o_addr_rb),
    .o_en_rb   (o_en_rb),
    .i_data_rb (i_data_rb),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_last    (o_last),
    .o_busy    (o_busy),
    .o_done    (o_done)
`ifdef REDUCE_DRAIN_CLEAR_EN
    ,
    .o_addr_clr(o_addr_clr),
    .o_we_clr  (o_we_clr),
    .o_data_clr(o_data_clr)
`endif
  );

  // BRAM model: refill on request, one-cycle registered read
  logic [EW-1:0] mem [1<<AW];
  logic [EW-1:0] rd_q;
  int fill_gen = 0;
  int fill_seen = 0;

  always @(posedge clk) begin
    if (fill_gen != fill_seen) begin
      for (int a = 0; a < (1 << AW); a++) mem[a] <= {DW'(a + 100), DW'(a)};
      fill_seen <= fill_gen;
    end else begin
`ifdef REDUCE_DRAIN_CLEAR_EN
      if (o_we_clr) mem[o_addr_clr] <= '0;
`endif
    end
    if (o_en_rb) rd_q <= mem[o_addr_rb];
  end
  assign i_data_rb = rd_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    fill_gen++;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int n, input bit wr_done, input bit zero);
    int cnt;
    cnt = 1 << ((n > AW) ? AW : n);
    for (int a = 0; a < cnt; a++)
      sb.push_back({(a == cnt - 1), zero ? {EW{1'b0}} : {DW'(a + 100), DW'(a)}});
    i_n       = 4'(n);
    i_wr_done = wr_done;
    i_start   = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every accepted beat
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      accepted++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_entry: got %0h, expected none", o_data);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("entry_data", 160'(o_data), 160'(mon_e[EW-1:0]));
        checkOutput("entry_last", 160'(o_last), 160'(mon_e[EW]));
      end
    end
  end

  task automatic run_drain(input int max_cyc, input int wr_done_cyc, input int ready_cyc);
`ifdef REDUCE_DRAIN_CLEAR_EN
    int clr_c [$];
    logic [AW-1:0] clr_a [$];
`endif
    res_first_valid = -1; res_first_en = -1; res_first_addr = -1; res_done = -1;
    res_en_blocked = 0; res_busy1 = -1; res_done1 = -1; res_held_bad = 0;
    res_clr_count = 0; res_head19 = '1;
    for (int c = 0; c < max_cyc; c++) begin
      if (c == wr_done_cyc) i_wr_done = 1'b1;
      if (c == ready_cyc) i_ready = 1'b1;
      @(negedge clk);
`ifdef REDUCE_DRAIN_CLEAR_EN
      if (o_we_clr) begin
        res_clr_count++;
        if (clr_a.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_clear: got %0h, expected none", o_addr_clr);
        end else begin
          checkOutput("clr_addr", 160'(o_addr_clr), 160'(clr_a.pop_front()));
          checkOutput("clr_cycle", 160'(c), 160'(clr_c.pop_front()));
        end
      end
      if (o_en_rb) begin
        clr_a.push_back(o_addr_rb);
        clr_c.push_back(c + 1);
      end
`endif
      if (o_en_rb && res_first_en < 0) begin
        res_first_en   = c;
        res_first_addr = int'(o_addr_rb);
      end
      if (o_en_rb && !i_ready) res_en_blocked++;
      if (c == 1) begin
        res_busy1 = int'(o_busy);
        res_done1 = int'(o_done);
      end
      if (o_valid && res_first_valid < 0) res_first_valid = c;
      if (o_valid && !i_ready && sb.size() > 0 && o_data !== sb[0][EW-1:0]) res_held_bad++;
      if (c == 19) res_head19 = o_data;
      if (c > 0 && o_done) begin
        res_done = c;
        tick();
        break;
      end
      tick();
      i_start = 1'b0;
    end
  endtask

  task automatic check_reset_values(input string p);
    @(negedge clk);
    checkOutput({p, "_valid"}, 160'(o_valid), 160'(0));
    checkOutput({p, "_en"},    160'(o_en_rb), 160'(0));
    checkOutput({p, "_addr"},  160'(o_addr_rb), 160'(0));
    checkOutput({p, "_data"},  160'(o_data), 160'(0));
    checkOutput({p, "_last"},  160'(o_last), 160'(0));
    checkOutput({p, "_busy"},  160'(o_busy), 160'(0));
    checkOutput({p, "_done"},  160'(o_done), 160'(1));
`ifdef REDUCE_DRAIN_CLEAR_EN
    checkOutput({p, "_we_clr"},   160'(o_we_clr), 160'(0));
    checkOutput({p, "_addr_clr"}, 160'(o_addr_clr), 160'(0));
`endif
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    rst_n = 1'b0; i_start = 1'b0; i_n = '0; i_wr_done = 1'b1; i_ready = 1'b1;
    fill_mem();
    tick();
    check_reset_values("por");
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] basic drain n=3");
    fill_mem();
    applyStimulus(3, 1'b1, 1'b0);
    run_drain(40, -1, -1);
    checkOutput("basic_first_valid", 160'(res_first_valid), 160'(3));
    checkOutput("basic_first_addr", 160'(res_first_addr), 160'(0));
    checkOutput("basic_done_cycle", 160'(res_done), 160'(11));
    checkOutput("basic_sb_empty", 160'(sb.size()), 160'(0));

    $display("[TB] wait for writer");
    fill_mem();
    applyStimulus(1, 1'b0, 1'b0);
    run_drain(40, 5, -1);
    checkOutput("wait_first_en_cycle", 160'(res_first_en), 160'(6));
    checkOutput("wait_first_en_addr", 160'(res_first_addr), 160'(0));
    checkOutput("wait_busy_c1", 160'(res_busy1), 160'(1));
    checkOutput("wait_done_c1", 160'(res_done1), 160'(0));
    checkOutput("wait_done_reached", 160'(res_done >= 0), 160'(1));
    checkOutput("wait_sb_empty", 160'(sb.size()), 160'(0));

    $display("[TB] backpressure n=4");
    fill_mem();
    i_ready = 1'b0;
    applyStimulus(4, 1'b1, 1'b0);
    run_drain(100, -1, 20);
    checkOutput("bp_reads_blocked", 160'(res_en_blocked), 160'(3));
    checkOutput("bp_head_held", 160'(res_head19), 160'({DW'(100), DW'(0)}));
    checkOutput("bp_hold_stable", 160'(res_held_bad), 160'(0));
    checkOutput("bp_sb_empty", 160'(sb.size()), 160'(0));

    $display("[TB] boundary n=0");
    fill_mem();
    applyStimulus(0, 1'b1, 1'b0);
    run_drain(40, -1, -1);
    checkOutput("n0_first_valid", 160'(res_first_valid), 160'(3));
    checkOutput("n0_done_cycle", 160'(res_done), 160'(4));
    checkOutput("n0_sb_empty", 160'(sb.size()), 160'(0));

    $display("[TB] boundary n=15");
    fill_mem();
    applyStimulus(15, 1'b1, 1'b0);
    run_drain(5000, -1, -1);
    checkOutput("n15_done_cycle", 160'(res_done), 160'(4099));
    checkOutput("n15_sb_empty", 160'(sb.size()), 160'(0));

    $display("[TB] reset mid-drain");
    fill_mem();
    applyStimulus(4, 1'b1, 1'b0);
    base = accepted;
    for (int c = 0; c < 60; c++) begin
      tick();
      i_start = 1'b0;
      if (accepted - base >= 5) break;
    end
    checkOutput("rst_entries_before", 160'(accepted - base), 160'(5));
    rst_n = 1'b0;
    sb.delete();
    check_reset_values("midrst");
    tick();
    rst_n = 1'b1;
    fill_mem();
    applyStimulus(2, 1'b1, 1'b0);
    run_drain(40, -1, -1);
    checkOutput("rst_done_cycle", 160'(res_done), 160'(7));
    checkOutput("rst_sb_empty", 160'(sb.size()), 160'(0));

`ifdef REDUCE_DRAIN_CLEAR_EN
    $display("[TB] clear write-back");
    fill_mem();
    applyStimulus(2, 1'b1, 1'b0);
    run_drain(40, -1, -1);
    checkOutput("clr_count", 160'(res_clr_count), 160'(4));
    checkOutput("clr_data_zero", 160'(o_data_clr), 160'(0));
    applyStimulus(2, 1'b1, 1'b1);
    run_drain(40, -1, -1);
    checkOutput("clr_second_sb_empty", 160'(sb.size()), 160'(0));
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reduce_buffer_drain_seq.md
Name: reduce_buffer_drain_seq

Overview:
- Read side of the reduce buffer filled by the cross-add last stage.
- Waits until the writer reports done, then sequentially reads 2^i_n entries, each holding two polynomial words.
- Streams the entries to the downstream consumer over a valid/ready handshake.
- Absorbs BRAM read latency with a credit-controlled output FIFO, so backpressure never loses data.

Parameters:
- DATA_WIDTH, 64, bit length of one polynomial word.
- ADDR_WIDTH, 12, reduce buffer address width.
- COMMON_BRAM_LATENCY, 1, reduce buffer read latency in cycles (>=1).
- Fixed localparams: N_POLY=2, LEVEL_WIDTH=4, FIFO_DEPTH=COMMON_BRAM_LATENCY+2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  request to drain; sampled only in IDLE.
- i_n  in  LEVEL_WIDTH  log2 of entry count; captured at start.
- i_wr_done  in  1  writer done level (high = buffer stable).
- o_addr_rb  out  ADDR_WIDTH  reduce buffer read address.
- o_en_rb  out  1  reduce buffer read enable.
- i_data_rb  in  N_POLY*DATA_WIDTH  read data, valid COMMON_BRAM_LATENCY cycles after o_en_rb.
- o_data  out  N_POLY*DATA_WIDTH  output entry, poly0 in LSBs.
- o_valid  out  1  o_data valid.
- i_ready  in  1  consumer accepts when o_valid & i_ready.
- o_last  out  1  qualifies the final entry, high with o_valid.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  level, high only in IDLE.

Behaviour:
- Reset values: o_valid=0, o_en_rb=0, o_addr_rb=0, o_data=0, o_last=0, o_busy=0, o_done=1. The FIFO and in-flight counter are cleared and the state goes to IDLE.
- Reset mid-drain aborts immediately. Data from reads already in flight is discarded.
- FSM state IDLE:
  - i_start captures i_n and clears the read counter.
  - If i_wr_done=1, go to DRAIN; otherwise go to WAIT.
- FSM state WAIT: go to DRAIN on the first cycle i_wr_done=1.
- FSM state DRAIN:
  - o_en_rb=1 combinationally when credits allow, i.e. fifo_count + inflight + (pop this cycle ? -1 : 0) < FIFO_DEPTH.
  - o_addr_rb = read counter; the counter increments on each issued read.
  - After the read of address N-1 is issued, go to FLUSH.
- FSM state FLUSH: stay until the FIFO is empty and inflight=0, then go to IDLE (o_done rises).
- Entry count: N = 2^min(i_n, ADDR_WIDTH). The counter is ADDR_WIDTH+1 bits wide, so N = 2^ADDR_WIDTH does not wrap early.
- Pipeline and FIFO:
  - The issue-valid bit is delayed COMMON_BRAM_LATENCY cycles through a shift register.
  - When the delayed bit is high, i_data_rb is written into the FIFO.
  - The FIFO is registered-output, first-word fall-through. An entry written at edge k is visible as o_valid=1 after edge k.
- Output: o_data and o_last hold stable while o_valid=1 and i_ready=0.
- o_last is a FIFO sideband bit, set on the entry read from address N-1.
- Latency: with i_ready=1 and i_wr_done=1, the first o_valid occurs COMMON_BRAM_LATENCY+2 cycles after the i_start cycle. After that, throughput is one entry per cycle.
- i_start in any state other than IDLE is ignored.
- A fall of i_wr_done during DRAIN is ignored; the drain continues.
- FIFO simultaneous push and pop in one cycle leaves the count unchanged.
- The credit rule guarantees the FIFO never overflows, for any i_ready pattern.
- i_n=0 drains exactly one entry, address 0, with o_last=1.

Optional Feature:
- Macro: REDUCE_DRAIN_CLEAR_EN.
- Defined:
  - Adds ports o_addr_clr (ADDR_WIDTH), o_we_clr (1) and o_data_clr (N_POLY*DATA_WIDTH, constant 0).
  - Each issued read address is delayed COMMON_BRAM_LATENCY cycles and driven onto o_addr_clr with o_we_clr=1. This writes zero back after the read data is captured, so the buffer is clean for the next accumulation.
  - Clear writes still in flight complete before FLUSH exits.
  - Reset values: o_we_clr=0, o_addr_clr=0.
- Not defined: these ports and their logic are absent. Buffer contents are left untouched.

Test Plan:
- Basic drain: i_n=3, i_wr_done=1, i_ready=1, buffer[a]={a+100,a}, pulse i_start in cycle 0 -> o_valid first high in cycle 3 (latency 1); 8 consecutive entries {100,0}..{107,7}; o_last only on {107,7}; o_done returns to 1 in cycle 11.
- Wait for writer: i_wr_done=0 at i_start, raised in cycle 5 -> o_en_rb stays 0 through cycle 5; first read at addr 0 in cycle 6; o_busy=1 and o_done=0 from cycle 1.
- Backpressure: i_n=4, i_ready=0 for 20 cycles then 1 -> o_en_rb issues at most FIFO_DEPTH=3 reads then stops; o_data stays {100,0}; after release all 16 entries arrive in order with no duplicates or gaps.
- Boundary: i_n=0 gives one entry at addr 0 with o_last=1. i_n=15 with ADDR_WIDTH=12 gives exactly 4096 entries, last address 4095 with o_last=1.
- Reset mid-operation: rst_n low at entry 5 of 16, then restart with i_n=2 -> outputs take reset values during reset; the new drain yields exactly entries 0..3 and no stale data.
- Macro REDUCE_DRAIN_CLEAR_EN with i_n=2 -> o_we_clr pulses at addresses 0..3, each one cycle after the matching read; a second drain then reads all zeros.
